// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hold/flush sequencer: load-use stalls, redirects and LM/SM micro-op expansion.
// Optional perf counters are enabled by defining HAZARD_CTRL_PERF_EN.
module pipeline_hazard_ctrl #(
  parameter int unsigned LOAD_USE_CYCLES = 1,
  parameter logic [3:0]  LM_OPC          = 4'b0110,
  parameter logic [3:0]  SM_OPC          = 4'b0111,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      id_ir,
  input  logic             rr_src1_used,
  input  logic [2:0]       rr_src1,
  input  logic             rr_src2_used,
  input  logic [2:0]       rr_src2,
  input  logic             ex_is_load,
  input  logic [2:0]       ex_dest,
  input  logic             redirect_rr,
  input  logic             redirect_ex,
`ifdef HAZARD_CTRL_PERF_EN
  input  logic             perf_clr,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt,
`endif
  output logic             pc_hold,
  output logic             pr1_hold,
  output logic             pr2_hold,
  output logic             flush_pr1,
  output logic             flush_pr2,
  output logic             flush_pr3,
  output logic             modify_ir,
  output logic [2:0]       modify_pr2_ra,
  output logic             first_multiple,
  output logic             multi_busy
);

  localparam int unsigned CW = (LOAD_USE_CYCLES > 1) ? $clog2(LOAD_USE_CYCLES) : 1;
  localparam logic StIdle  = 1'b0;
  localparam logic StMulti = 1'b1;

  logic          state_q, state_d;
  logic [7:0]    mask_q, mask_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hazard, stall, is_multi_op, rr_taken;
  logic [7:0]    cur_mask, rem_mask;
  logic          unused_ir_bits;

  assign unused_ir_bits = ^id_ir[11:8];

  function automatic logic [2:0] lowest_bit(input logic [7:0] m);
    lowest_bit = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) lowest_bit = 3'(i);
    end
  endfunction

  assign hazard = ex_is_load & ((rr_src1_used & (rr_src1 == ex_dest)) |
                                (rr_src2_used & (rr_src2 == ex_dest)));
  assign stall       = hazard | (cnt_q != '0);
  assign is_multi_op = (id_ir[15:12] == LM_OPC) | (id_ir[15:12] == SM_OPC);
  assign cur_mask    = (state_q == StMulti) ? mask_q : id_ir[7:0];
  assign rem_mask    = cur_mask & (cur_mask - 8'd1);
  assign rr_taken    = ~reset & ~redirect_ex & ~stall & redirect_rr;

  always_comb begin
    pc_hold        = 1'b0;
    pr1_hold       = 1'b0;
    pr2_hold       = 1'b0;
    flush_pr1      = 1'b0;
    flush_pr2      = 1'b0;
    flush_pr3      = 1'b0;
    modify_ir      = 1'b0;
    modify_pr2_ra  = 3'd0;
    first_multiple = 1'b0;
    multi_busy     = ~reset & (state_q == StMulti);
    state_d        = state_q;
    mask_d         = mask_q;
    cnt_d          = cnt_q;
    if (reset) begin
      state_d = StIdle;
      mask_d  = '0;
      cnt_d   = '0;
    end else if (redirect_ex) begin
      flush_pr1 = 1'b1;
      flush_pr2 = 1'b1;
      flush_pr3 = 1'b1;
      state_d   = StIdle;
      mask_d    = '0;
      cnt_d     = '0;
    end else if (stall) begin
      // Walk state is frozen; the stalled micro-op is re-presented afterwards.
      pc_hold   = 1'b1;
      pr1_hold  = 1'b1;
      pr2_hold  = 1'b1;
      flush_pr3 = 1'b1;
      cnt_d     = (cnt_q == '0) ? CW'(LOAD_USE_CYCLES - 1) : cnt_q - CW'(1);
    end else if (redirect_rr) begin
      flush_pr1 = 1'b1;
      flush_pr2 = 1'b1;
      state_d   = StIdle;
      mask_d    = '0;
    end else if ((state_q == StMulti) || is_multi_op) begin
      if (cur_mask == '0) begin
        flush_pr2 = 1'b1;
      end else begin
        modify_ir      = 1'b1;
        modify_pr2_ra  = lowest_bit(cur_mask);
        first_multiple = (state_q == StIdle);
        if (rem_mask != '0) begin
          pc_hold  = 1'b1;
          pr1_hold = 1'b1;
          state_d  = StMulti;
          mask_d   = rem_mask;
        end else begin
          state_d = StIdle;
          mask_d  = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    mask_q  <= mask_d;
    cnt_q   <= cnt_d;
  end

`ifdef HAZARD_CTRL_PERF_EN
  logic stall_evt, flush_evt;
  assign stall_evt = ~reset & ~redirect_ex & stall;
  assign flush_evt = (~reset & redirect_ex) | rr_taken;

  always_ff @(posedge clk) begin
    if (reset || perf_clr) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall_evt && (perf_stall_cnt != '1)) perf_stall_cnt <= perf_stall_cnt + 1'b1;
      if (flush_evt && (perf_flush_cnt != '1)) perf_flush_cnt <= perf_flush_cnt + 1'b1;
    end
  end
`else
  logic unused_rr_taken;
  assign unused_rr_taken = rr_taken;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; expected output vectors go through a scoreboard queue.
module tb_pipeline_hazard_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] id_ir;
  logic        rr_src1_used, rr_src2_used, ex_is_load, redirect_rr, redirect_ex;
  logic [2:0]  rr_src1, rr_src2, ex_dest;
  logic        pc_hold, pr1_hold, pr2_hold, flush_pr1, flush_pr2, flush_pr3;
  logic        modify_ir, first_multiple, multi_busy;
  logic [2:0]  modify_pr2_ra;
`ifdef HAZARD_CTRL_PERF_EN
  logic        perf_clr;
  logic [1:0]  perf_stall_cnt, perf_flush_cnt;
`endif

  int checks = 0;
  int failures = 0;
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(2)) dut (
    .clk(clk), .reset(reset), .id_ir(id_ir),
    .rr_src1_used(rr_src1_used), .rr_src1(rr_src1),
    .rr_src2_used(rr_src2_used), .rr_src2(rr_src2),
    .ex_is_load(ex_is_load), .ex_dest(ex_dest),
    .redirect_rr(redirect_rr), .redirect_ex(redirect_ex),
`ifdef HAZARD_CTRL_PERF_EN
    .perf_clr(perf_clr), .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
    .pc_hold(pc_hold), .pr1_hold(pr1_hold), .pr2_hold(pr2_hold),
    .flush_pr1(flush_pr1), .flush_pr2(flush_pr2), .flush_pr3(flush_pr3),
    .modify_ir(modify_ir), .modify_pr2_ra(modify_pr2_ra),
    .first_multiple(first_multiple), .multi_busy(multi_busy)
  );

  // holds = {pc,pr1,pr2}, flushes = {pr1,pr2,pr3}
  function automatic logic [11:0] mk(input logic [2:0] holds, input logic [2:0] flushes,
                                     input logic mod, input logic [2:0] ra,
                                     input logic first, input logic busy);
    return {holds, flushes, mod, ra, first, busy};
  endfunction

  task automatic step(input logic [11:0] e, input string tag);
    logic [11:0] got, want;
    exp_q.push_back(e);
    #4;
    got = {pc_hold, pr1_hold, pr2_hold, flush_pr1, flush_pr2, flush_pr3,
           modify_ir, modify_pr2_ra, first_multiple, multi_busy};
    want = exp_q.pop_front();
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, got, want);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    id_ir = 16'h0; rr_src1_used = 0; rr_src1 = 0; rr_src2_used = 0; rr_src2 = 0;
    ex_is_load = 0; ex_dest = 0; redirect_rr = 0; redirect_ex = 0;
  endtask

  initial begin
    quiet();
`ifdef HAZARD_CTRL_PERF_EN
    perf_clr = 0;
`endif
    // 1: reset with every request active
    reset = 1; id_ir = 16'h60A4; ex_is_load = 1; ex_dest = 3; rr_src2_used = 1; rr_src2 = 3;
    redirect_ex = 1; redirect_rr = 1;
    step(mk(3'b000, 3'b000, 0, 0, 0, 0), "reset_c0");
    step(mk(3'b000, 3'b000, 0, 0, 0, 0), "reset_c1");
    reset = 0; quiet();
    step(mk(3'b000, 3'b000, 0, 0, 0, 0), "idle_after_reset");

    // 2: LM mask A4
    id_ir = 16'h60A4;
    step(mk(3'b110, 3'b000, 1, 3'd2, 1, 0), "lm_uop0");
    step(mk(3'b110, 3'b000, 1, 3'd5, 0, 1), "lm_uop1");
    step(mk(3'b000, 3'b000, 1, 3'd7, 0, 1), "lm_uop2");
    id_ir = 16'h0;
    step(mk(3'b000, 3'b000, 0, 0, 0, 0), "lm_done");

    // 3: load-use on src2, then unused src1 match must not stall
    ex_is_load = 1; ex_dest = 3; rr_src2_used = 1; rr_src2 = 3;
    step(mk(3'b111, 3'b001, 0, 0, 0, 0), "load_stall");
    rr_src2_used = 0; rr_src1 = 3; rr_src1_used = 0;
    step(mk(3'b000, 3'b000, 0, 0, 0, 0), "src1_unused_no_stall");
    rr_src1_used = 1;
    step(mk(3'b111, 3'b001, 0, 0, 0, 0), "load_stall_src1");
    quiet();
    step(mk(3'b000, 3'b000, 0, 0, 0, 0), "after_stall");

    // 4: SM FF cut by redirect_ex
    id_ir = 16'h70FF;
    step(mk(3'b110, 3'b000, 1, 3'd0, 1, 0), "sm_uop0");
    redirect_ex = 1;
    step(mk(3'b000, 3'b111, 0, 0, 0, 1), "redirect_ex");
    quiet();
    step(mk(3'b000, 3'b000, 0, 0, 0, 0), "after_redirect_ex");

    // 5: empty SM mask, then redirect_rr masked by a load stall
    id_ir = 16'h7000;
    step(mk(3'b000, 3'b010, 0, 0, 0, 0), "sm_empty");
    id_ir = 16'h0; ex_is_load = 1; ex_dest = 5; rr_src1_used = 1; rr_src1 = 5; redirect_rr = 1;
    step(mk(3'b111, 3'b001, 0, 0, 0, 0), "rr_ignored_in_stall");
    ex_is_load = 0;
    step(mk(3'b000, 3'b110, 0, 0, 0, 0), "redirect_rr");
    quiet();

    // stall mid-walk freezes the walk; reset mid-walk returns to idle
    id_ir = 16'h6003;
    step(mk(3'b110, 3'b000, 1, 3'd0, 1, 0), "walk_uop0");
    ex_is_load = 1; ex_dest = 1; rr_src1_used = 1; rr_src1 = 1;
    step(mk(3'b111, 3'b001, 0, 0, 0, 1), "walk_stalled");
    ex_is_load = 0;
    step(mk(3'b000, 3'b000, 1, 3'd1, 0, 1), "walk_resume_last");
    quiet(); id_ir = 16'h6003;
    step(mk(3'b110, 3'b000, 1, 3'd0, 1, 0), "walk2_uop0");
    reset = 1;
    step(mk(3'b000, 3'b000, 0, 0, 0, 0), "reset_mid_walk");
    reset = 0; id_ir = 16'h0;
    step(mk(3'b000, 3'b000, 0, 0, 0, 0), "idle_after_mid_reset");

`ifdef HAZARD_CTRL_PERF_EN
    // 6: saturating counters
    perf_clr = 1;
    step(mk(3'b000, 3'b000, 0, 0, 0, 0), "perf_clr_cycle");
    perf_clr = 0; ex_is_load = 1; ex_dest = 2; rr_src2_used = 1; rr_src2 = 2;
    for (int i = 0; i < 5; i++) step(mk(3'b111, 3'b001, 0, 0, 0, 0), "perf_stall");
    #4;
    checks++;
    assert (perf_stall_cnt === 2'd3) else begin
      failures++;
      $error("FAIL perf_stall_sat observed=%0d expected=3", perf_stall_cnt);
    end
    quiet(); perf_clr = 1; redirect_ex = 1;
    @(posedge clk); #1;
    perf_clr = 0;
    #4;
    checks++;
    assert (perf_stall_cnt === 2'd0 && perf_flush_cnt === 2'd0) else begin
      failures++;
      $error("FAIL perf_clr observed=%0d/%0d expected=0/0", perf_stall_cnt, perf_flush_cnt);
    end
    @(posedge clk); #1;
    redirect_ex = 0;
    #4;
    checks++;
    assert (perf_flush_cnt === 2'd1) else begin
      failures++;
      $error("FAIL perf_flush_cnt observed=%0d expected=1", perf_flush_cnt);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
